// File: rtl/ones_frame_accumulator_pkg.sv
// ones_pkg: shared state encoding and in_count clamping for the frame accumulator
package ones_pkg;
  typedef enum logic {ACCUM, HOLD} state_t;
  localparam logic [3:0] MAX_COUNT = 4'd8;
  function automatic logic [3:0] clamp(input logic [3:0] c);
    return (c > MAX_COUNT) ? MAX_COUNT : c;
  endfunction
endpackage

// File: rtl/ones_frame_accumulator_if.sv
// ones_frame_accumulator_if: count-in and frame-result valid/ready ports
interface ones_frame_accumulator_if #(parameter int SUM_W = 8);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_count;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic [7:0]       out_bytes;
  logic             out_over;
  logic             err_range;
  modport master (output in_valid, in_count, in_last, out_ready,
                  input in_ready, out_valid, out_sum, out_bytes, out_over, err_range);
  modport slave (input in_valid, in_count, in_last, out_ready,
                 output in_ready, out_valid, out_sum, out_bytes, out_over, err_range);
endinterface

// File: rtl/ones_frame_accumulator_ctrl.sv
// ones_frame_ctrl: ACCUM/HOLD sequencing and both handshakes of the accumulator
module ones_frame_ctrl
  import ones_pkg::*;
#(
  parameter int FRAME_LEN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_last,
  input  logic       out_ready,
  input  logic [7:0] byte_cnt,
  output logic       in_ready,
  output logic       out_valid,
  output logic       accept,
  output logic       close,
  output logic       out_fire
);
  state_t state, state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ACCUM;
    else        state <= state_nx;
  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == HOLD);
    accept    = in_ready && in_valid;
    close     = accept && (in_last || (9'(byte_cnt) + 9'd1 == 9'(FRAME_LEN)));
    out_fire  = out_valid && out_ready;
    state_nx  = close ? HOLD : out_fire ? ACCUM : state;
  end
endmodule

// File: rtl/ones_frame_accumulator.sv
// ones_frame_accumulator: sums per-byte ones counts over a frame and reports total, length and threshold
module ones_frame_accumulator
  import ones_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int SUM_W     = 8,
  parameter int THRESH    = 64
) (
  input logic clk,
  input logic rst_n,
  ones_frame_accumulator_if.slave bus
);
  logic [SUM_W-1:0] sum, sum_nx, out_sum;
  logic [7:0]       byte_cnt, out_bytes;
  logic             out_over, err_range;
  logic             in_ready, out_valid, accept, close, out_fire;
  ones_frame_ctrl #(.FRAME_LEN(FRAME_LEN)) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_last   (bus.in_last),
    .out_ready (bus.out_ready),
    .byte_cnt  (byte_cnt),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .accept    (accept),
    .close     (close),
    .out_fire  (out_fire)
  );
  assign sum_nx = sum + SUM_W'(clamp(bus.in_count));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sum       <= '0;
      byte_cnt  <= '0;
      out_sum   <= '0;
      out_bytes <= '0;
      out_over  <= 1'b0;
      err_range <= 1'b0;
    end else begin
      if (accept) begin
        sum      <= sum_nx;
        byte_cnt <= byte_cnt + 8'd1;
        if (bus.in_count > MAX_COUNT) err_range <= 1'b1;
      end
      if (close) begin
        out_sum   <= sum_nx;
        out_bytes <= byte_cnt + 8'd1;
        out_over  <= (sum_nx >= SUM_W'(THRESH));
      end
      if (out_fire) begin
        sum      <= '0;
        byte_cnt <= '0;
      end
    end
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_sum   = out_sum;
  assign bus.out_bytes = out_bytes;
  assign bus.out_over  = out_over;
  assign bus.err_range = err_range;
endmodule

// File: tb/tb_ones_frame_accumulator.sv
// tb_ones_frame_accumulator: table vectors, directed corner sequences and random traffic vs a queue model
module tb_ones_frame_accumulator;
  localparam int FRAME_LEN = 16;
  localparam int SUM_W     = 8;
  localparam int THRESH    = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ones_frame_accumulator_if #(.SUM_W(SUM_W)) bus ();
  ones_frame_accumulator #(.FRAME_LEN(FRAME_LEN), .SUM_W(SUM_W), .THRESH(THRESH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  int errors = 0;
  int checks = 0;
  int frame_q[$];
  bit holding = 0;
  bit m_err = 0;
  int m_sum = 0;
  int m_bytes = 0;
  bit m_over = 0;
  typedef struct {
    logic       v;
    logic [3:0] c;
    logic       l;
    logic       r;
    logic       ir;
    logic       ov;
    int         sum;
    int         bytes;
    logic       over;
    logic       err;
  } vec_t;
  vec_t tbl[10];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_step(input bit v, input int c, input bit l, input bit r);
    if (holding) begin
      if (r) begin
        holding = 0;
        frame_q.delete();
      end
    end else if (v) begin
      frame_q.push_back(c > 8 ? 8 : c);
      if (c > 8) m_err = 1;
      if (l || frame_q.size() == FRAME_LEN) begin
        holding = 1;
        m_sum = 0;
        foreach (frame_q[i]) m_sum += frame_q[i];
        m_bytes = frame_q.size();
        m_over = (m_sum >= THRESH);
      end
    end
  endtask
  task automatic model_check(input string tag);
    chk({tag, " in_ready"}, int'(bus.in_ready), int'(!holding));
    chk({tag, " out_valid"}, int'(bus.out_valid), int'(holding));
    chk({tag, " err_range"}, int'(bus.err_range), int'(m_err));
    chk({tag, " out_sum"}, int'(bus.out_sum), m_sum);
    chk({tag, " out_bytes"}, int'(bus.out_bytes), m_bytes);
    chk({tag, " out_over"}, int'(bus.out_over), int'(m_over));
  endtask
  task automatic tick(input string tag, input bit v, input int c, input bit l, input bit r);
    bus.in_valid = v;
    bus.in_count = 4'(c);
    bus.in_last  = l;
    bus.out_ready = r;
    model_step(v, c, l, r);
    @(posedge clk);
    #1;
    model_check(tag);
  endtask
  task automatic apply_reset();
    rst_n = 1'b0;
    holding = 0;
    frame_q.delete();
    m_err = 0;
    m_sum = 0;
    m_bytes = 0;
    m_over = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    if (2 ** SUM_W <= 8 * FRAME_LEN) begin
      $display("FAIL param: 2^SUM_W=%0d not above 8*FRAME_LEN=%0d", 2 ** SUM_W, 8 * FRAME_LEN);
      $fatal(1);
    end
    bus.in_valid = 0;
    bus.in_count = 0;
    bus.in_last = 0;
    bus.out_ready = 0;
    // short frame 3,5,0; range-error frame 12,1 held then released; single beat of 8
    tbl[0] = '{1'b1, 4'd3,  1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 4'd5,  1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 8, 3, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 4'd12, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 4'd1,  1'b1, 1'b0, 1'b0, 1'b1, 9, 2, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 9, 2, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 4'd7,  1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 4'd8,  1'b1, 1'b0, 1'b0, 1'b1, 8, 1, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1};
    #2;
    apply_reset();
    chk("reset in_ready", int'(bus.in_ready), 1);
    chk("reset out_valid", int'(bus.out_valid), 0);
    chk("reset out_sum", int'(bus.out_sum), 0);
    chk("reset out_bytes", int'(bus.out_bytes), 0);
    chk("reset out_over", int'(bus.out_over), 0);
    chk("reset err_range", int'(bus.err_range), 0);
    for (int i = 0; i < 10; i++) begin
      tick("table", tbl[i].v, int'(tbl[i].c), tbl[i].l, tbl[i].r);
      chk($sformatf("tbl%0d in_ready", i), int'(bus.in_ready), int'(tbl[i].ir));
      chk($sformatf("tbl%0d out_valid", i), int'(bus.out_valid), int'(tbl[i].ov));
      chk($sformatf("tbl%0d err_range", i), int'(bus.err_range), int'(tbl[i].err));
      if (tbl[i].ov) begin
        chk($sformatf("tbl%0d out_sum", i), int'(bus.out_sum), tbl[i].sum);
        chk($sformatf("tbl%0d out_bytes", i), int'(bus.out_bytes), tbl[i].bytes);
        chk($sformatf("tbl%0d out_over", i), int'(bus.out_over), int'(tbl[i].over));
      end
    end
    for (int i = 0; i < FRAME_LEN; i++) begin
      tick("full", 1, 4, 0, 1);
      chk("full latency", int'(bus.out_valid), int'(i == FRAME_LEN - 1));
    end
    chk("full out_sum", int'(bus.out_sum), 64);
    chk("full out_bytes", int'(bus.out_bytes), 16);
    chk("full out_over", int'(bus.out_over), 1);
    chk("full in_ready low", int'(bus.in_ready), 0);
    tick("full", 1, 4, 0, 1);
    chk("full in_ready back", int'(bus.in_ready), 1);
    chk("full err sticky", int'(bus.err_range), 1);
    tick("full", 0, 0, 0, 0);
    for (int i = 0; i < FRAME_LEN; i++) tick("bp", 1, 2, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick("bp hold", 1, 7, i[0], 0);
      chk("bp out_sum stable", int'(bus.out_sum), 32);
      chk("bp in_ready", int'(bus.in_ready), 0);
    end
    tick("bp release", 1, 1, 0, 1);
    tick("bp next", 1, 1, 0, 1);
    tick("bp next", 1, 2, 1, 0);
    chk("bp next out_sum", int'(bus.out_sum), 3);
    chk("bp next out_bytes", int'(bus.out_bytes), 2);
    tick("bp next", 0, 0, 0, 1);
    for (int i = 0; i < FRAME_LEN; i++) tick("last16", 1, 5, i == FRAME_LEN - 1, 0);
    chk("last16 out_bytes", int'(bus.out_bytes), 16);
    chk("last16 out_sum", int'(bus.out_sum), 80);
    tick("last16", 0, 0, 0, 1);
    tick("last16 idle", 0, 0, 0, 1);
    chk("last16 no repeat", int'(bus.out_valid), 0);
    tick("single", 1, 8, 1, 0);
    chk("single out_bytes", int'(bus.out_bytes), 1);
    chk("single out_sum", int'(bus.out_sum), 8);
    tick("single", 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) tick("midrst", 1, 8, 0, 1);
    apply_reset();
    chk("midrst out_valid", int'(bus.out_valid), 0);
    chk("midrst err cleared", int'(bus.err_range), 0);
    chk("midrst out_sum", int'(bus.out_sum), 0);
    for (int i = 0; i < FRAME_LEN; i++) tick("midrst ones", 1, 1, 0, 0);
    chk("midrst ones sum", int'(bus.out_sum), 16);
    chk("midrst ones bytes", int'(bus.out_bytes), 16);
    tick("midrst", 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      int c;
      c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      tick("rand", $urandom_range(0, 9) < 7, c, $urandom_range(0, 19) < 3, $urandom_range(0, 9) < 6);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ones_frame_accumulator.md
Name: ones_frame_accumulator

Overview:
Downstream consumer of the per-byte ones counter (8-bit in, 4-bit count out). It accepts one 4-bit ones-count per valid/ready beat and accumulates a running total over a frame of up to FRAME_LEN bytes. At end of frame it presents the total, the byte count and a threshold flag on a valid/ready output port. It sits between the combinational popcount stage and the lab's result/display logic.

Parameters:
FRAME_LEN, 16, bytes per frame (2..255); frame closes on the FRAME_LEN-th accepted beat.
SUM_W, 8, width of the accumulated sum; must satisfy 2^SUM_W > 8*FRAME_LEN.
THRESH, 64, out_over asserts when the frame sum is >= THRESH.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  upstream beat valid.
in_ready  output  1  block can accept a beat.
in_count  input  4  ones count for one byte; legal range 0..8.
in_last  input  1  marks the final beat of a short frame; qualified by in_valid.
out_valid  output  1  frame result available.
out_ready  input  1  downstream accepts the result.
out_sum  output  SUM_W  total ones in the frame.
out_bytes  output  8  number of beats accepted in the frame (1..FRAME_LEN).
out_over  output  1  out_sum >= THRESH.
err_range  output  1  sticky flag: an in_count value above 8 was seen.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state=ACCUM, sum=0, byte_cnt=0, out_valid=0, out_sum=0, out_bytes=0, out_over=0, err_range=0, in_ready=1 (combinational from state).
- FSM has two states, ACCUM and HOLD.
- ACCUM:
  - in_ready=1 and out_valid=0.
  - A beat is accepted when in_valid && in_ready.
  - On accept: sum += clamp(in_count), byte_cnt += 1.
  - If in_count > 8, the value 8 is added and err_range is set.
  - If the accepted beat has in_last=1, or byte_cnt+1 == FRAME_LEN, the frame closes. On the next edge: out_sum = final sum including this beat, out_bytes = byte_cnt+1, out_over = (final sum >= THRESH), out_valid=1, state=HOLD.
  - Latency: out_valid rises exactly 1 cycle after the closing beat is accepted.
- HOLD:
  - in_ready=0, so upstream stalls and no beat is accepted.
  - out_sum, out_bytes and out_over hold stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid=0, sum=0, byte_cnt=0, state=ACCUM.
  - in_ready returns to 1 in the cycle after the output handshake. There is no same-cycle input/output overlap.
- out_* registers keep their last frame values after the handshake until the next frame closes; they are valid only while out_valid=1.
- in_last asserted together with byte_cnt+1 == FRAME_LEN closes a single frame. It is not counted twice.
- in_last on the first beat gives out_bytes=1.
- in_valid=0 in ACCUM: no state change; a partial frame waits indefinitely.
- Arithmetic: the sum is unsigned SUM_W bits. No overflow is possible given the parameter constraint; the bench also checks the constraint.
- err_range clears only on reset.
- Reset mid-frame or in HOLD: the partial or pending frame is discarded, all registers return to reset values, and nothing is emitted.

Decomposition:
- Shared package ones_pkg:
  - state enum {ACCUM, HOLD}
  - localparam MAX_COUNT = 4'd8
  - clamp function for in_count
- Natural single sub-module: ones_frame_ctrl (FSM plus handshake logic).
- The datapath (sum, byte_cnt, output registers) stays in the top module. Both pieces fit in one file if preferred.

Test Plan:
- Full frame: 16 beats of in_count=4 back-to-back, out_ready=1 -> out_valid 1 cycle after the 16th beat; out_sum=64, out_bytes=16, out_over=1; in_ready=0 for exactly 1 cycle.
- Short frame: counts 3,5,0 with in_last on the 3rd beat -> out_sum=8, out_bytes=3, out_over=0.
- Backpressure: frame closes with out_ready=0 for 5 cycles -> outputs stable, in_ready=0 and in_valid ignored throughout; after out_ready=1, the next frame starts from sum 0.
- Range error: in_count=4'd12 on one beat of a 2-beat frame with the other beat 1 -> out_sum=9, err_range=1 and sticky across the following frames.
- Reset mid-frame: 7 beats of 8, then rst_n low for 1 cycle -> no out_valid; a following 16-beat frame of 1s gives out_sum=16.
- Boundary: in_last on the 16th beat, and a single-beat frame with in_count=8 and in_last -> one frame each; out_bytes=16 and 1 respectively.
